// File: rtl/pwm_multi.sv
// N-channel PWM generator sharing one period counter, with edge or center-aligned
// counting and double-buffered configuration applied only at period boundaries.
module pwm_multi #(
    parameter int WIDTH = 8,
    parameter int NCH   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 cfg_wr,
    input  logic [WIDTH-1:0]     period,
    input  logic                 center,
    input  logic [NCH*WIDTH-1:0] duty,
    output logic [NCH-1:0]       PWM_sig,
    output logic                 period_end,
    output logic                 update_pend
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0]     cnt, cnt_nxt;
    dir_t                 dir, dir_nxt;
    logic [WIDTH-1:0]     period_act, period_pnd;
    logic                 center_act, center_pnd;
    logic [NCH*WIDTH-1:0] duty_act, duty_pnd;
    logic                 boundary, apply;
    logic [NCH-1:0]       cmp;

    always_comb begin
        cnt_nxt = '0;
        dir_nxt = DIR_UP;
        if (!center_act) begin
            cnt_nxt = (cnt == period_act) ? '0 : cnt + ONE;
        end else if (period_act != '0) begin
            if (dir == DIR_UP && cnt != period_act) begin
                cnt_nxt = cnt + ONE;
                dir_nxt = DIR_UP;
            end else begin
                cnt_nxt = cnt - ONE;
                dir_nxt = DIR_DOWN;
            end
        end
        // A period ends whenever the counter is about to return to zero; the
        // direction override covers P == 1, where the turn-around lands on zero.
        boundary = en && (cnt_nxt == '0);
        if (boundary) begin
            dir_nxt = DIR_UP;
        end
        apply = boundary || !en;
    end

    always_comb begin
        cmp = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            cmp[i] = cnt < duty_act[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            dir         <= DIR_UP;
            period_act  <= '1;
            center_act  <= 1'b0;
            duty_act    <= '0;
            period_pnd  <= '1;
            center_pnd  <= 1'b0;
            duty_pnd    <= '0;
            PWM_sig     <= '0;
            period_end  <= 1'b0;
            update_pend <= 1'b0;
        end else begin
            PWM_sig    <= en ? cmp : '0;
            period_end <= boundary;
            if (cfg_wr) begin
                period_pnd <= period;
                center_pnd <= center;
                duty_pnd   <= duty;
            end
            if (apply) begin
                cnt         <= '0;
                dir         <= DIR_UP;
                update_pend <= 1'b0;
                // Pending always mirrors active once applied, so reloading it is harmless.
                if (cfg_wr) begin
                    period_act <= period;
                    center_act <= center;
                    duty_act   <= duty;
                end else begin
                    period_act <= period_pnd;
                    center_act <= center_pnd;
                    duty_act   <= duty_pnd;
                end
            end else begin
                cnt <= cnt_nxt;
                dir <= dir_nxt;
                if (cfg_wr) begin
                    update_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: a period-position reference model predicts
// every output cycle; a separate monitor pops and compares.
module tb_pwm_multi;

    localparam int WIDTH = 8;
    localparam int NCH   = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b0;
    logic                 cfg_wr = 1'b0;
    logic [WIDTH-1:0]     period = '0;
    logic                 center = 1'b0;
    logic [NCH*WIDTH-1:0] duty = '0;
    logic [NCH-1:0]       PWM_sig;
    logic                 period_end;
    logic                 update_pend;

    pwm_multi #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .cfg_wr      (cfg_wr),
        .period      (period),
        .center      (center),
        .duty        (duty),
        .PWM_sig     (PWM_sig),
        .period_end  (period_end),
        .update_pend (update_pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] pwm;
        logic           pe;
        logic           up;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: position within the period, plus active/pending config.
    int m_P, m_ctr, m_duty[NCH];
    int p_P, p_ctr, p_duty[NCH];
    int m_upd, m_pos;

    function automatic int m_len();
        if (m_ctr != 0) return (m_P == 0) ? 1 : 2 * m_P;
        return m_P + 1;
    endfunction

    function automatic int m_cnt();
        if (m_ctr != 0 && m_pos > m_P) return 2 * m_P - m_pos;
        return m_pos;
    endfunction

    task automatic model_reset();
        m_P = 2**WIDTH - 1; m_ctr = 0;
        p_P = m_P;          p_ctr = 0;
        for (int i = 0; i < NCH; i++) begin
            m_duty[i] = 0;
            p_duty[i] = 0;
        end
        m_upd = 0;
        m_pos = 0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Drives one clock's inputs and pushes the outputs expected after that edge.
    task automatic step(input bit e, input bit w, input int p, input bit c, input int d0, input int d1);
        exp_t x;
        int   cnt;
        bit   last;
        @(posedge clk);
        #2;
        en     = e;
        cfg_wr = w;
        if (w) begin
            period = p[WIDTH-1:0];
            center = c;
            duty   = {d1[WIDTH-1:0], d0[WIDTH-1:0]};
        end
        cnt  = m_cnt();
        last = (m_pos == m_len() - 1);
        x.pwm[0] = e && (cnt < m_duty[0]);
        x.pwm[1] = e && (cnt < m_duty[1]);
        x.pe     = e && last;
        if (!e || last) begin
            if (w) begin
                m_P = p; m_ctr = c; m_duty[0] = d0; m_duty[1] = d1;
            end else if (m_upd != 0) begin
                m_P = p_P; m_ctr = p_ctr; m_duty[0] = p_duty[0]; m_duty[1] = p_duty[1];
            end
            m_upd = 0;
            m_pos = 0;
        end else begin
            m_pos++;
            if (w) begin
                p_P = p; p_ctr = c; p_duty[0] = d0; p_duty[1] = d1;
                m_upd = 1;
            end
        end
        x.up = (m_upd != 0);
        sb.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic cfg(input int p, input bit c, input int d0, input int d1);
        step(1'b1, 1'b1, p, c, d0, d1);
    endtask

    task automatic idle_until_pos(input int pos);
        for (int k = 0; k < 600 && m_pos != pos; k++) idle(1);
    endtask

    task automatic idle_until_applied();
        for (int k = 0; k < 600 && m_upd != 0; k++) idle(1);
    endtask

    // Holds reset with en high and the clock running, then releases it.
    task automatic reset_hold_release(input string tag);
        cfg_wr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check({tag, "_pwm"}, PWM_sig, 0);
            check({tag, "_pe"}, period_end, 0);
            check({tag, "_upd"}, update_pend, 0);
        end
        en = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic async_reset();
        @(posedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        check("async_rst_pwm", PWM_sig, 0);
        check("async_rst_pe", period_end, 0);
        check("async_rst_upd", update_pend, 0);
        reset_hold_release("async_rst_hold");
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("pwm_sig", PWM_sig, x.pwm);
                check("period_end", period_end, x.pe);
                check("update_pend", update_pend, x.up);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int p, d0, d1;
        bit e, w, c;
        model_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        #1;
        check("rst_pwm", PWM_sig, 0);
        check("rst_pe", period_end, 0);
        check("rst_upd", update_pend, 0);
        reset_hold_release("rst_hold");
        idle(520);

        cfg(9, 1'b0, 3, 0);
        idle_until_applied();
        idle(30);

        cfg(9, 1'b0, 9, 10);
        idle_until_applied();
        idle(30);
        cfg(0, 1'b0, 1, 0);
        idle_until_applied();
        idle(10);

        cfg(4, 1'b1, 2, 0);
        idle_until_applied();
        idle(24);

        cfg(9, 1'b0, 3, 0);
        idle_until_applied();
        idle_until_pos(4);
        cfg(9, 1'b0, 7, 0);
        idle(25);
        idle_until_pos(9);
        cfg(9, 1'b0, 5, 0);
        idle(20);

        idle_until_pos(2);
        cfg(9, 1'b0, 2, 0);
        idle_until_pos(5);
        step(1'b0, 1'b0, 0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 1'b0, 0, 0);
        idle(25);

        idle_until_pos(2);
        cfg(9, 1'b0, 8, 8);
        idle_until_pos(4);
        async_reset();
        idle(20);

        for (int k = 0; k < 3000; k++) begin
            e  = ($urandom_range(0, 59) != 0);
            w  = ($urandom_range(0, 29) == 0);
            c  = $urandom_range(0, 1);
            p  = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 12);
            d0 = $urandom_range(0, p + 2);
            d1 = $urandom_range(0, p + 2);
            if (d0 > 255) d0 = 255;
            if (d1 > 255) d1 = 255;
            step(e, w, p, c, d0, d1);
        end

        @(posedge clk);
        #3;
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Parametrised N-channel PWM generator. Successor to the fixed 8-bit single-channel PWM.
- All channels share one period counter. Width and channel count are parameters.
- Period is programmable. Edge-aligned or center-aligned (up/down) counting.
- Configuration is double-buffered and takes effect only at a period boundary, so no glitched or truncated pulses.
- Sits between the control/register logic and the motor/LED drivers.

Parameters:
- WIDTH, 8, bit width of counter, period and each duty value.
- NCH, 2, number of PWM channels.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run enable.
- cfg_wr  input  1  single-cycle strobe; captures period, center and duty into pending registers.
- period  input  WIDTH  terminal count P.
- center  input  1  mode: 0 = edge-aligned, 1 = center-aligned.
- duty  input  NCH*WIDTH  channel i duty in bits [i*WIDTH +: WIDTH].
- PWM_sig  output  NCH  PWM outputs, registered.
- period_end  output  1  registered pulse, high for one cycle after each boundary cycle.
- update_pend  output  1  high while a captured configuration awaits application.

Behaviour:
- Reset (async, immediate):
  - cnt = 0, dir = up.
  - Active period = all ones, active mode = edge, active duties = 0.
  - Pending registers hold the same values as active.
  - PWM_sig = 0, period_end = 0, update_pend = 0.
- Edge mode count sequence: 0, 1, ..., P, then 0. Period length is P+1 cycles.
- Center mode count sequence: 0, 1, ..., P, P-1, ..., 1, then 0.
  - Period length is 2P cycles.
  - dir flips to down on the cycle cnt == P and back to up when cnt returns to 0.
  - P == 1 gives 0, 1, 0, 1, ...
  - P == 0 in either mode: cnt stays 0 and every cycle is a boundary.
- Boundary cycle: the cycle whose next cnt is 0 while en = 1.
- Channel compare: PWM_sig[i] <= en & (cnt < duty_act[i]), unsigned, evaluated on the current cnt and active duty.
  - Output lags cnt by one cycle.
  - duty = 0 gives a constant low output.
  - duty > P (edge) or duty > P (center) gives a constant high output.
  - Edge: duty = P gives high for P of P+1 cycles.
- Config capture and application:
  - cfg_wr = 1 loads period, center and all duties into the pending registers and sets update_pend.
  - A later cfg_wr before application overwrites pending; last write wins.
  - On a boundary cycle, active <= pending and update_pend clears.
  - If cfg_wr coincides with a boundary cycle, the bus values bypass pending and go straight to active. update_pend stays 0.
  - Applying a new mode or period also forces dir = up, cnt = 0. Counting always restarts from 0.
- period_end:
  - Registered. High exactly one cycle, on the first cycle of each new period.
  - Never asserted while en = 0.
- en = 0:
  - Next cycle: cnt = 0, dir = up, PWM_sig = 0.
  - Pending config is applied immediately, with the same bypass rule for a simultaneous cfg_wr.
  - On en rising, counting starts from cnt = 0 on the next edge. The first period is full length.
- Arithmetic:
  - cnt never exceeds P. No wrap beyond WIDTH bits.
  - If P is reduced, it is applied only at a boundary, so no out-of-range cnt can occur.
- Reset asserted mid-period: all state returns to reset values asynchronously and outputs drop low at once. The pending update is discarded.

Test Plan:
- Reset: hold rst_n = 0 with en = 1 and clk running -> PWM_sig = 00, period_end = 0, update_pend = 0. Release, with no cfg_wr -> outputs stay 00; period_end pulses every 256 cycles.
- Edge mode (WIDTH = 8, NCH = 2): P = 9, duty0 = 3, duty1 = 0, en = 1 -> ch0 high 3 of every 10 cycles, contiguous at period start; ch1 always 0; period_end every 10 cycles.
- Extremes: P = 9, duty0 = 9, duty1 = 10 -> ch0 high 9 of 10 cycles; ch1 constant 1. Then P = 0, duty0 = 1 -> ch0 constant 1 and period_end every cycle.
- Center mode: P = 4, duty0 = 2 -> cnt sequence 0,1,2,3,4,3,2,1 repeating; ch0 high 3 of 8 cycles, centred on cnt = 0; period_end every 8 cycles.
- Deferred update: mid-period with P = 9, cfg_wr with duty0 = 7 -> update_pend high until the boundary; ch0 keeps a 3-cycle pulse in the current period; 7-cycle pulse from the next period. Then cfg_wr exactly on a boundary cycle -> applied to the following period, update_pend never rises.
- Enable/reset mid-period: drop en at cnt = 5 -> PWM_sig = 00 next cycle, cnt = 0, pending applied; re-raise en -> full first period. Assert rst_n low at cnt = 4 -> outputs 0 immediately, pending discarded after release.
